// File: rtl/mul_f_core.sv
// Iterative radix-2 shift-and-add unsigned multiplier for the FPU mantissa path.
// One multiplier bit is consumed per clock; the product is held in {hi_reg, lo_reg}.
module mul_f_core #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] init_val,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] res
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  assign op_a = init_val[2*WIDTH-1:WIDTH];
  assign op_b = init_val[WIDTH-1:0];

  // Carry is kept in sum[WIDTH] and lands in hi_reg's MSB on the right shift.
  assign sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      a_reg  <= '0;
      hi_reg <= '0;
      lo_reg <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (op_a == '0 || op_b == '0) begin
              hi_reg <= '0;
              lo_reg <= '0;
              state  <= S_DONE;
            end else begin
              a_reg  <= op_a;
              hi_reg <= '0;
              lo_reg <= op_b;
              cnt    <= CNT_W'(WIDTH - 1);
              state  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          hi_reg <= sum[WIDTH:1];
          lo_reg <= {sum[0], lo_reg[WIDTH-1:1]};
          if (cnt == '0) begin
            state <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
  assign res  = {hi_reg, lo_reg};

endmodule

// File: tb/tb_mul_f_core.sv
// Testbench for mul_f_core: vector table, hand-written corner sequences and
// random operands checked against a plain-arithmetic product model.
module tb_mul_f_core;

  localparam int WIDTH = 24;
  localparam int LAT   = 24;

  logic               clk;
  logic               rst;
  logic               start;
  logic [2*WIDTH-1:0] init_val;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] res;

  int checks;
  int errors;

  typedef struct {
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] p;
    int                 lat;
  } vec_t;

  vec_t vecs[8];

  mul_f_core #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .init_val (init_val),
    .busy     (busy),
    .done     (done),
    .res      (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start pulse; returns one edge after the start-sampling edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start    = 1'b1;
    init_val = {a, b};
    tick();
    start    = 1'b0;
  endtask

  // Counts further edges until done, scrambling init_val meanwhile.
  task automatic waitDone(output int n);
    n = 0;
    while (!done && n < 100) begin
      init_val = {$urandom, $urandom};
      tick();
      n++;
    end
  endtask

  task automatic runOp(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [2*WIDTH-1:0] p, input int lat);
    int n;
    applyStimulus(a, b);
    checkOutput({name, " busy after start"}, 64'(busy), 64'(lat != 0));
    checkOutput({name, " done after start"}, 64'(done), 64'(lat == 0));
    waitDone(n);
    checkOutput({name, " latency"}, 64'(n + 1), 64'(lat + 1));
    checkOutput({name, " res"}, 64'(res), 64'(p));
    checkOutput({name, " busy at done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    int last;
    int pulses;
    logic prev_done;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [63:0] model;

    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    init_val = '0;

    vecs[0] = '{a: 24'hFFFFFF, b: 24'hFFFFFF, p: 48'hFFFFFE000001, lat: LAT};
    vecs[1] = '{a: 24'h800000, b: 24'h800000, p: 48'h400000000000, lat: LAT};
    vecs[2] = '{a: 24'hC00000, b: 24'hA00000, p: 48'h780000000000, lat: LAT};
    vecs[3] = '{a: 24'h123456, b: 24'h000000, p: 48'h0,            lat: 0};
    vecs[4] = '{a: 24'h000000, b: 24'hFFFFFF, p: 48'h0,            lat: 0};
    vecs[5] = '{a: 24'h000001, b: 24'h000001, p: 48'h1,            lat: LAT};
    vecs[6] = '{a: 24'hFFFFFF, b: 24'h000001, p: 48'hFFFFFF,       lat: LAT};
    vecs[7] = '{a: 24'h000003, b: 24'h000005, p: 48'hF,            lat: LAT};

    #1;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset res", 64'(res), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].lat);
    end

    // Result is held in DONE while start stays low.
    repeat (3) tick();
    checkOutput("hold done", 64'(done), 64'd1);
    checkOutput("hold res", 64'(res), 64'hF);

    // Start during RUN is ignored.
    applyStimulus(24'd3, 24'd5);
    repeat (5) tick();
    start    = 1'b1;
    init_val = {24'd7, 24'd9};
    tick();
    start    = 1'b0;
    waitDone(n);
    checkOutput("ignore latency", 64'(n + 6), 64'(LAT));
    checkOutput("ignore res", 64'(res), 64'd15);
    runOp("rearm", 24'd7, 24'd9, 48'd63, LAT);

    // Asynchronous reset mid-RUN clears outputs without a clock edge.
    applyStimulus(24'd2, 24'd3);
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async rst busy", 64'(busy), 64'd0);
    checkOutput("async rst done", 64'(done), 64'd0);
    checkOutput("async rst res", 64'(res), 64'd0);
    #2;
    rst = 1'b0;
    tick();
    checkOutput("post rst busy", 64'(busy), 64'd0);
    runOp("after rst", 24'd2, 24'd3, 48'd6, LAT);

    // Start held high: one single-cycle done pulse per operation.
    start     = 1'b1;
    init_val  = {24'd1, 24'd1};
    last      = -1;
    pulses    = 0;
    prev_done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done) begin
        pulses++;
        checkOutput("held start res", 64'(res), 64'd1);
        checkOutput("held start pulse width", 64'(prev_done), 64'd0);
        if (last >= 0) checkOutput("held start period", 64'(i - last), 64'(LAT + 1));
        last = i;
      end
      prev_done = done;
    end
    start = 1'b0;
    checkOutput("held start pulses", 64'(pulses), 64'd3);
    waitDone(n);

    // Random operands against the arithmetic product model.
    for (int i = 0; i < 20; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (i % 7 == 3) ra = '0;
      if (i % 9 == 5) rb = '0;
      model = {40'd0, ra} * {40'd0, rb};
      runOp($sformatf("rand%0d", i), ra, rb, model[2*WIDTH-1:0],
            (ra == '0 || rb == '0) ? 0 : LAT);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
